// File: rtl/console_pkg.sv
// Shared types and constants for the console UART bridge.
// Holds the RX/TX FSM state enums, the data-bit count and the default bit period.
`timescale 1ns/1ps
package console_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/console_fifo.sv
// Small synchronous FIFO buffering received console bytes.
// Ports: clk, rst (async active-high), push/push_data (write), pop (read),
//        head (oldest entry), empty, full (registered flags).
`timescale 1ns/1ps
module console_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_pop;
  logic             do_push;

  // A pop on a full FIFO frees the slot that a same-cycle push uses.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Occupancy update
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage, pointers (wrap naturally) and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_console_bridge.sv
// Bridges the Wrapper console byte interface to an 8N1 UART.
// Ports: CLK, RESET (async active-high); UART_RX/UART_TX serial pins;
//        CONSOLE_IN/_valid/_ack toward the Wrapper (FIFO head);
//        CONSOLE_OUT/_valid/_ready from the Wrapper (TX handshake);
//        RX_OVERRUN sticky drop flag, RX_FRAME_ERR one-cycle bad-stop pulse.
`timescale 1ns/1ps
module uart_console_bridge
  import console_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic       UART_TX,
  output logic [7:0] CONSOLE_IN,
  output logic       CONSOLE_IN_valid,
  input  logic       CONSOLE_IN_ack,
  input  logic [7:0] CONSOLE_OUT,
  input  logic       CONSOLE_OUT_valid,
  output logic       CONSOLE_OUT_ready,
  output logic       RX_OVERRUN,
  output logic       RX_FRAME_ERR
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_BITS - 1);

  // ---------------- receive path ----------------
  logic                      rx_meta;
  logic                      rx_sync;
  rx_state_t                 rx_state, rx_state_next;
  logic [CNT_W-1:0]          rx_cnt, rx_cnt_next;
  logic [2:0]                rx_idx, rx_idx_next;
  logic [UART_DATA_BITS-1:0] rx_shift, rx_shift_next;
  logic                      rx_push;
  logic                      frame_err_next;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_pop;

  // Two-flop synchroniser; idles high so reset looks like an idle line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // RX state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      RX_FRAME_ERR <= 1'b0;
    end else begin
      rx_state     <= rx_state_next;
      rx_cnt       <= rx_cnt_next;
      rx_idx       <= rx_idx_next;
      rx_shift     <= rx_shift_next;
      RX_FRAME_ERR <= frame_err_next;
    end
  end

  // RX next-state: half-bit wait lands later samples mid-bit
  always_comb begin
    rx_state_next  = rx_state;
    rx_cnt_next    = rx_cnt;
    rx_idx_next    = rx_idx;
    rx_shift_next  = rx_shift;
    rx_push        = 1'b0;
    frame_err_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_next = RX_START;
          rx_cnt_next   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_sync) begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = BIT_RELOAD;
            rx_idx_next   = '0;
          end else begin
            rx_state_next = RX_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          rx_cnt_next = rx_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_next = {rx_sync, rx_shift[UART_DATA_BITS-1:1]};
          rx_cnt_next   = BIT_RELOAD;
          if (rx_idx == LAST_BIT) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_idx_next = rx_idx + 3'(1);
          end
        end else begin
          rx_cnt_next = rx_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_next = RX_IDLE;
          if (rx_sync) begin
            rx_push = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt - CNT_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign fifo_pop         = CONSOLE_IN_valid && CONSOLE_IN_ack;
  assign CONSOLE_IN_valid = !fifo_empty;

  console_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .head      (CONSOLE_IN),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Sticky overrun: push dropped only if no same-cycle pop frees a slot
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RX_OVERRUN <= 1'b0;
    end else if (rx_push && fifo_full && !fifo_pop) begin
      RX_OVERRUN <= 1'b1;
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t                 tx_state, tx_state_next;
  logic [CNT_W-1:0]          tx_cnt, tx_cnt_next;
  logic [2:0]                tx_idx, tx_idx_next;
  logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_next;
  logic                      tx_line_next;

  assign CONSOLE_OUT_ready = (tx_state == TX_IDLE);

  // TX state register; line output registered so it idles high in reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      UART_TX  <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_idx   <= tx_idx_next;
      tx_shift <= tx_shift_next;
      UART_TX  <= tx_line_next;
    end
  end

  // TX next-state: the line value for each bit is set on the entering edge
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    tx_line_next  = UART_TX;
    case (tx_state)
      TX_IDLE: begin
        tx_line_next = 1'b1;
        if (CONSOLE_OUT_valid) begin
          tx_state_next = TX_START;
          tx_shift_next = CONSOLE_OUT;
          tx_cnt_next   = BIT_RELOAD;
          tx_line_next  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = BIT_RELOAD;
          tx_idx_next   = '0;
          tx_line_next  = tx_shift[0];
        end else begin
          tx_cnt_next = tx_cnt - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_next = BIT_RELOAD;
          if (tx_idx == LAST_BIT) begin
            tx_state_next = TX_STOP;
            tx_line_next  = 1'b1;
          end else begin
            tx_idx_next   = tx_idx + 3'(1);
            tx_shift_next = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
            tx_line_next  = tx_shift[1];
          end
        end else begin
          tx_cnt_next = tx_cnt - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          tx_state_next = TX_IDLE;
          tx_line_next  = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt - CNT_W'(1);
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_console_bridge.sv
// Self-checking bench for uart_console_bridge (CLKS_PER_BIT=4, depth 4).
// Reference model: a byte queue with overrun flag, serial waveforms from bit arithmetic.
`timescale 1ns/1ps
module tb_uart_console_bridge;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] CONSOLE_IN;
  logic       CONSOLE_IN_valid;
  logic       CONSOLE_IN_ack;
  logic [7:0] CONSOLE_OUT;
  logic       CONSOLE_OUT_valid;
  logic       CONSOLE_OUT_ready;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q [$];
  logic       model_ovr;
  int         ferr;

  uart_console_bridge #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .UART_RX           (UART_RX),
    .UART_TX           (UART_TX),
    .CONSOLE_IN        (CONSOLE_IN),
    .CONSOLE_IN_valid  (CONSOLE_IN_valid),
    .CONSOLE_IN_ack    (CONSOLE_IN_ack),
    .CONSOLE_OUT       (CONSOLE_OUT),
    .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
    .RX_OVERRUN        (RX_OVERRUN),
    .RX_FRAME_ERR      (RX_FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare the console side against the model queue
  task automatic check_fifo(input string tag);
    check({tag, "_valid"}, 32'(CONSOLE_IN_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check({tag, "_data"}, 32'(CONSOLE_IN), 32'(model_q[0]));
    end
    check({tag, "_ovr"}, 32'(RX_OVERRUN), 32'(model_ovr));
  endtask

  // Serialise one 8N1 frame on UART_RX; count frame-error pulses seen
  task automatic send_rx(input logic [7:0] b, input logic stop, output int errs);
    logic lvl;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      lvl = 1'b0;
      else if (i == 9) lvl = stop;
      else             lvl = b[i-1];
      UART_RX = lvl;
      repeat (CPB) begin
        tick();
        if (RX_FRAME_ERR) errs++;
      end
    end
    UART_RX = 1'b1;
    repeat (6) begin
      tick();
      if (RX_FRAME_ERR) errs++;
    end
    if (stop) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else                        model_ovr = 1'b1;
    end
  endtask

  // Hand one byte to the transmitter and check every cycle of the frame
  task automatic send_tx(input logic [7:0] b);
    int   guard;
    logic lvl;
    int   bitpos;
    guard = 0;
    while (!CONSOLE_OUT_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("tx_ready_wait", 32'(guard < 100), 32'd1);
    CONSOLE_OUT       = b;
    CONSOLE_OUT_valid = 1'b1;
    tick();
    CONSOLE_OUT_valid = 1'b0;
    check("tx_ready_fall", 32'(CONSOLE_OUT_ready), 32'd0);
    for (int k = 0; k < 10 * int'(CPB); k++) begin
      bitpos = k / int'(CPB);
      if (bitpos == 0)      lvl = 1'b0;
      else if (bitpos == 9) lvl = 1'b1;
      else                  lvl = b[bitpos-1];
      check("tx_line", 32'(UART_TX), 32'(lvl));
      tick();
    end
    check("tx_ready_rise", 32'(CONSOLE_OUT_ready), 32'd1);
    check("tx_idle_high", 32'(UART_TX), 32'd1);
  endtask

  task automatic do_ack(input string tag);
    CONSOLE_IN_ack = 1'b1;
    tick();
    CONSOLE_IN_ack = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    check_fifo(tag);
  endtask

  initial begin
    logic [7:0] rb;
    RESET             = 1'b1;
    UART_RX           = 1'b1;
    CONSOLE_IN_ack    = 1'b0;
    CONSOLE_OUT       = 8'h00;
    CONSOLE_OUT_valid = 1'b0;
    model_ovr         = 1'b0;

    // Reset state
    #3;
    check("rst_ready_during", 32'(CONSOLE_OUT_ready), 32'd1);
    check("rst_tx_during", 32'(UART_TX), 32'd1);
    #7;
    RESET = 1'b0;
    tick();
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_ready", 32'(CONSOLE_OUT_ready), 32'd1);
    check("rst_valid", 32'(CONSOLE_IN_valid), 32'd0);
    check("rst_data", 32'(CONSOLE_IN), 32'd0);
    check("rst_ovr", 32'(RX_OVERRUN), 32'd0);
    check("rst_ferr", 32'(RX_FRAME_ERR), 32'd0);

    // Transmit 0x41
    send_tx(8'h41);

    // Receive 0x5A, hold without ack, then ack once
    send_rx(8'h5A, 1'b1, ferr);
    check("rx5a_ferr", 32'(ferr), 32'd0);
    check_fifo("rx5a");
    repeat (5) tick();
    check_fifo("rx5a_stable");
    do_ack("rx5a_ack");
    do_ack("ack_empty");

    // Overrun: five bytes, no ack
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i), 1'b1, ferr);
      check("ovr_ferr", 32'(ferr), 32'd0);
      check_fifo("ovr_fill");
    end
    for (int i = 0; i < 4; i++) do_ack("ovr_drain");
    check("ovr_empty", 32'(CONSOLE_IN_valid), 32'd0);

    // One-cycle glitch is rejected
    UART_RX = 1'b0;
    tick();
    UART_RX = 1'b1;
    repeat (10) tick();
    check_fifo("glitch");

    // Bad stop bit
    send_rx(8'h33, 1'b0, ferr);
    check("ferr_pulses", 32'(ferr), 32'd1);
    check_fifo("ferr_fifo");

    // Reset mid-transmit and mid-receive
    send_rx(8'hC3, 1'b1, ferr);
    check_fifo("pre_reset");
    CONSOLE_OUT       = 8'hFF;
    CONSOLE_OUT_valid = 1'b1;
    UART_RX           = 1'b0;
    tick();
    CONSOLE_OUT_valid = 1'b0;
    repeat (2) tick();
    check("mid_tx_start", 32'(UART_TX), 32'd0);
    RESET = 1'b1;
    #1;
    check("mid_rst_tx", 32'(UART_TX), 32'd1);
    check("mid_rst_ready", 32'(CONSOLE_OUT_ready), 32'd1);
    check("mid_rst_valid", 32'(CONSOLE_IN_valid), 32'd0);
    model_q.delete();
    model_ovr = 1'b0;
    tick();
    UART_RX = 1'b1;
    RESET   = 1'b0;
    repeat (6) tick();
    check_fifo("post_reset");
    rb = 8'($urandom);
    send_rx(rb, 1'b1, ferr);
    check("post_rst_ferr", 32'(ferr), 32'd0);
    check_fifo("post_reset_rx");
    send_tx(8'($urandom));
    do_ack("post_reset_ack");

    // Randomised traffic against the queue model
    for (int it = 0; it < 10; it++) begin
      rb = 8'($urandom);
      send_rx(rb, 1'b1, ferr);
      check("rand_ferr", 32'(ferr), 32'd0);
      check_fifo("rand_rx");
      if ($urandom_range(0, 2) == 0) do_ack("rand_ack");
      if ($urandom_range(0, 3) == 0) send_tx(8'($urandom));
    end
    while (model_q.size() != 0) do_ack("final_drain");
    check("final_empty", 32'(CONSOLE_IN_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_console_bridge.md
Name: uart_console_bridge

Overview:
- Board-side peer of the processor Wrapper's console port: bridges the console byte interface to a physical 8N1 UART.
- Drives CONSOLE_IN / CONSOLE_IN_valid and consumes CONSOLE_IN_ack toward the Wrapper.
- Drives CONSOLE_OUT_ready and consumes CONSOLE_OUT / CONSOLE_OUT_valid from the Wrapper.
- Sits in the top-level between the Wrapper and the board UART pins; received bytes are buffered in a small FIFO.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); legal range is 4 or more.
- RX_FIFO_DEPTH, 4, receive buffer entries; power of two, 2 or more.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- UART_RX  in  1  serial input from the host, idle high; asynchronous to CLK.
- UART_TX  out  1  serial output to the host, idle high.
- CONSOLE_IN  out  8  received byte presented to the Wrapper; equals the FIFO head.
- CONSOLE_IN_valid  out  1  FIFO not empty.
- CONSOLE_IN_ack  in  1  Wrapper consumed CONSOLE_IN; honoured only while valid is high.
- CONSOLE_OUT  in  8  byte from the Wrapper to transmit.
- CONSOLE_OUT_valid  in  1  CONSOLE_OUT holds a byte.
- CONSOLE_OUT_ready  out  1  transmitter idle and able to accept a byte.
- RX_OVERRUN  out  1  sticky flag: a byte was dropped because the FIFO was full.
- RX_FRAME_ERR  out  1  one-cycle pulse when a received stop bit samples low.

Behaviour:
- Reset values: UART_TX=1, CONSOLE_IN_valid=0, CONSOLE_IN=0, RX_OVERRUN=0, RX_FRAME_ERR=0, FIFO empty, both FSMs in IDLE, all counters 0.
- CONSOLE_OUT_ready = (tx_state==IDLE), combinational, so it reads 1 during reset.
- Reset mid-frame aborts immediately; no partial byte is pushed or completed.

Receive path:
- UART_RX passes through a 2-flop synchroniser; the FSM sees only the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronised low.
- START: wait CLKS_PER_BIT/2 cycles, then resample. If still low, go to DATA; if high (glitch), return to IDLE.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into rx_shift.
- STOP: sample after CLKS_PER_BIT cycles.
  - High: push rx_shift into the FIFO.
  - Low: pulse RX_FRAME_ERR and discard the byte.
  - Either way, return to IDLE.
- Push while the FIFO is full: drop the byte, set RX_OVERRUN (cleared only by RESET); FIFO contents are unchanged.

FIFO to Wrapper:
- CONSOLE_IN shows the head entry and is stable while valid is high.
- Pop occurs on a cycle where CONSOLE_IN_valid and CONSOLE_IN_ack are both high. The next entry appears the following cycle, or valid falls if the FIFO is then empty.
- Ack while valid is low is ignored.
- Simultaneous push and pop in the same cycle:
  - Both take effect, count unchanged.
  - When full, the push succeeds because the pop frees a slot.
  - When empty, no pop occurs and the push lands.
- Pointers are log2(RX_FIFO_DEPTH) bits wide and wrap naturally. The count register is one bit wider than the pointers.

Transmit path:
- TX FSM states: IDLE, START, DATA, STOP.
- Handshake: a byte is accepted on a cycle where CONSOLE_OUT_valid and CONSOLE_OUT_ready are both high; CONSOLE_OUT is latched into tx_shift.
- UART_TX goes low on the cycle after acceptance.
- Each bit is held exactly CLKS_PER_BIT cycles: start bit (0), then 8 data bits LSB first, then stop bit (1).
- After the stop bit's last cycle the FSM returns to IDLE and ready rises. Back-to-back bytes therefore occupy 10*CLKS_PER_BIT cycles per byte plus 1 accept cycle.
- Valid without ready: the byte is not taken; the Wrapper holds it.

Arithmetic:
- Bit-period counters are $clog2(CLKS_PER_BIT) bits wide and count down to 0.
- Bit index counters are 3 bits wide.

Decomposition:
- Package console_pkg holds:
  - rx_state_t and tx_state_t enums;
  - UART_DATA_BITS=8;
  - the default CLKS_PER_BIT constant.
- One sub-module: console_fifo (synchronous FIFO).
  - Parameters: WIDTH, DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
  - Asynchronous active-high reset.
- The UART RX/TX FSMs stay in uart_console_bridge.

Test Plan (all with CLKS_PER_BIT=4, RX_FIFO_DEPTH=4):
- Reset held for 10 ns, released -> UART_TX=1, CONSOLE_OUT_ready=1, CONSOLE_IN_valid=0, RX_OVERRUN=0.
- Drive 0x41 on CONSOLE_OUT with valid for one cycle while ready=1 -> ready falls next cycle. UART_TX shows 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles. Ready returns after 40 cycles.
- Serialise 0x5A on UART_RX with ack held 0 -> CONSOLE_IN_valid rises within 2+2 cycles of the stop-bit sample, CONSOLE_IN=0x5A and stays stable. A one-cycle ack -> valid=0 the next cycle.
- Serialise 0x01,0x02,0x03,0x04,0x05 with no ack -> FIFO holds 0x01..0x04 and RX_OVERRUN=1. Four acks read 0x01,0x02,0x03,0x04 in order, then valid=0.
- Pulse UART_RX low for 1 cycle -> START aborts, nothing pushed. A frame with stop bit 0 -> RX_FRAME_ERR pulses for 1 cycle and the FIFO is unchanged.
- Assert RESET mid-transmit of 0xFF and mid-receive -> UART_TX=1 immediately, FIFO empty, ready=1; the next full byte in each direction completes correctly.
